ifc_mux_master: RTL and testbench

- Parametrised successor to the single-channel bus master used on the `ifc` bus.
- Accepts N_CH independent valid/ready request streams, buffers each stream in a per-channel FIFO, arbitrates between them, and drives one registered valid/ready output stream tagged with the source channel id.
- Sits between stimulus sources (VPI-driven or sequence-driven) and the `ifc` master modport in the top-level bench.

---
 rtl/ifc_mux_pkg.sv | 17 +
 rtl/ifc_ch_fifo.sv | 45 ++++
 rtl/ifc_mux_master.sv | 104 ++++++++++
 tb/tb_ifc_mux_master.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifc_mux_pkg.sv
// Shared types and helpers for the ifc multi-channel master.
// Provides channel-id width helper, arbitration mode enum and channel limit.
package ifc_mux_pkg;

   localparam int MAX_CH = 16;

   typedef enum logic {
      ARB_RR,
      ARB_PRIO
   } arb_mode_e;

   // Channel-id width, never narrower than one bit.
   function automatic int ch_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ifc_ch_fifo.sv
// Per-channel synchronous FIFO with extra-MSB wrap pointers.
// Ports: clk, rst (async high), push/wdata in, pop/rdata out, full, empty.
module ifc_ch_fifo
   import ifc_mux_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]       wptr;
   logic [AW:0]       rptr;
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   // Storage needs no reset: pointers alone define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rptr[AW-1:0]];
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) &&
                  (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/ifc_mux_master.sv
// N-channel valid/ready mux: per-channel FIFOs, RR or fixed-priority
// arbiter, one registered output tagged with source channel.
// Ports: clk, rst (async high); in_valid/in_ready/in_data per channel;
// out_valid/out_ready/out_data/out_ch; ch_empty per channel.
module ifc_mux_master
   import ifc_mux_pkg::*;
#(
   parameter int  DATA_W = 64,
   parameter int  N_CH   = 4,
   parameter int  DEPTH  = 4,
   parameter int  MODE   = 0,
   localparam int CH_W   = ch_w(N_CH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_CH-1:0]        in_valid,
   output logic [N_CH-1:0]        in_ready,
   input  logic [N_CH*DATA_W-1:0] in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [CH_W-1:0]        out_ch,
   output logic [N_CH-1:0]        ch_empty
);

   logic [N_CH-1:0]   full;
   logic [N_CH-1:0]   empty;
   logic [N_CH-1:0]   push;
   logic [N_CH-1:0]   pop;
   logic [DATA_W-1:0] rdata [N_CH];
   logic [CH_W-1:0]   ptr;
   logic [CH_W-1:0]   gnt;
   logic [CH_W-1:0]   nptr;
   logic              any;
   logic              load;

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      ifc_ch_fifo #(
         .DATA_W(DATA_W),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk  (clk),
         .rst  (rst),
         .push (push[gi]),
         .pop  (pop[gi]),
         .wdata(in_data[gi*DATA_W +: DATA_W]),
         .rdata(rdata[gi]),
         .full (full[gi]),
         .empty(empty[gi])
      );
   end

   assign push     = in_valid & ~full;
   assign in_ready = ~full;
   assign ch_empty = empty;
   assign any      = ~&empty;
   assign load     = !out_valid || out_ready;

   // First non-empty channel, scanning from ptr (RR) or from 0 (prio).
   always_comb begin
      logic            found;
      logic [CH_W-1:0] c;
      gnt   = '0;
      found = 1'b0;
      c     = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (MODE == int'(ARB_PRIO)) c = CH_W'(i);
         else                        c = CH_W'((int'(ptr) + i) % N_CH);
         if (!found && !empty[c]) begin
            found = 1'b1;
            gnt   = c;
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < N_CH; i++) begin
         pop[i] = load && any && (gnt == CH_W'(i));
      end
   end

   // Explicit wrap: N_CH need not be a power of two.
   assign nptr = (gnt == CH_W'(N_CH - 1)) ? '0 : gnt + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= '0;
      end else if (load) begin
         if (any) begin
            out_valid <= 1'b1;
            out_data  <= rdata[gnt];
            out_ch    <= gnt;
            if (MODE == int'(ARB_RR)) ptr <= nptr;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ifc_mux_master.sv
// Bench for ifc_mux_master: RR and priority instances on shared stimulus,
// compared cycle by cycle against a queue-based reference model.
module tb_ifc_mux_master;

   localparam int DW = 64;
   localparam int NC = 4;
   localparam int DP = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [NC-1:0] in_valid;
   logic [NC*DW-1:0] in_data;
   logic          out_ready;

   logic [NC-1:0] rdy0, rdy1, emp0, emp1;
   logic          ov0, ov1;
   logic [DW-1:0] od0, od1;
   logic [1:0]    oc0, oc1;

   always #5 clk = ~clk;

   ifc_mux_master #(
      .DATA_W(DW), .N_CH(NC), .DEPTH(DP), .MODE(0)
   ) u_rr (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
      .out_valid(ov0), .out_ready(out_ready),
      .out_data(od0), .out_ch(oc0), .ch_empty(emp0)
   );

   ifc_mux_master #(
      .DATA_W(DW), .N_CH(NC), .DEPTH(DP), .MODE(1)
   ) u_pr (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
      .out_valid(ov1), .out_ready(out_ready),
      .out_data(od1), .out_ch(oc1), .ch_empty(emp1)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: index 0 = round-robin, 1 = fixed priority.
   logic [DW-1:0] q [2][NC][$];
   bit            m_ov  [2];
   logic [DW-1:0] m_od  [2];
   int            m_och [2];
   int            m_ptr [2];

   function automatic void model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int c = 0; c < NC; c++) q[m][c].delete();
         m_ov[m]  = 1'b0;
         m_od[m]  = '0;
         m_och[m] = 0;
         m_ptr[m] = 0;
      end
   endfunction

   function automatic logic [NC-1:0] m_rdy(input int m);
      logic [NC-1:0] r;
      for (int c = 0; c < NC; c++) r[c] = (q[m][c].size() < DP);
      return r;
   endfunction

   function automatic logic [NC-1:0] m_emp(input int m);
      logic [NC-1:0] e;
      for (int c = 0; c < NC; c++) e[c] = (q[m][c].size() == 0);
      return e;
   endfunction

   function automatic void model_step();
      for (int m = 0; m < 2; m++) begin
         logic [NC-1:0] rdy;
         int g;
         rdy = m_rdy(m);
         if (!m_ov[m] || out_ready) begin
            g = -1;
            for (int i = 0; i < NC; i++) begin
               int c;
               c = (m == 0) ? (m_ptr[m] + i) % NC : i;
               if (g < 0 && q[m][c].size() > 0) g = c;
            end
            if (g >= 0) begin
               m_ov[m]  = 1'b1;
               m_od[m]  = q[m][g].pop_front();
               m_och[m] = g;
               if (m == 0) m_ptr[m] = (g + 1) % NC;
            end else begin
               m_ov[m] = 1'b0;
            end
         end
         for (int c = 0; c < NC; c++)
            if (in_valid[c] && rdy[c]) q[m][c].push_back(in_data[c*DW +: DW]);
      end
   endfunction

   task automatic cmp_all();
      check("rr_valid", 64'(ov0), 64'(m_ov[0]));
      check("rr_data",  od0,       m_od[0]);
      check("rr_ch",    64'(oc0),  64'(m_och[0]));
      check("rr_ready", 64'(rdy0), 64'(m_rdy(0)));
      check("rr_empty", 64'(emp0), 64'(m_emp(0)));
      check("pr_valid", 64'(ov1), 64'(m_ov[1]));
      check("pr_data",  od1,       m_od[1]);
      check("pr_ch",    64'(oc1),  64'(m_och[1]));
      check("pr_ready", 64'(rdy1), 64'(m_rdy(1)));
      check("pr_empty", 64'(emp1), 64'(m_emp(1)));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cmp_all();
   endtask

   // Asserts rst between edges, checks the immediate effect, releases on
   // the following falling edge.
   task automatic do_reset();
      #2 rst = 1'b1;
      in_valid  = '0;
      out_ready = 1'b0;
      #1;
      model_reset();
      check("rst_valid", 64'(ov0 | ov1), 64'h0);
      check("rst_data",  od0 | od1,      64'h0);
      check("rst_ch",    64'(oc0 | oc1), 64'h0);
      check("rst_ready", 64'({rdy1, rdy0}), 64'hFF);
      check("rst_empty", 64'({emp1, emp0}), 64'hFF);
      @(negedge clk);
      rst = 1'b0;
   endtask

   int exp_pr [4] = '{1, 1, 3, 3};
   int exp_rr [4] = '{1, 3, 1, 3};

   initial begin
      rst       = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b0;
      do_reset();

      // Single beat through an idle block.
      out_ready = 1'b1;
      in_valid  = 4'b0100;
      in_data[2*DW +: DW] = 64'hA5;
      cycle();
      check("basic_e1_valid", 64'(ov0), 64'h0);
      in_valid = '0;
      cycle();
      check("basic_e2_valid", 64'(ov0), 64'h1);
      check("basic_e2_data",  od0,      64'hA5);
      check("basic_e2_ch",    64'(oc0), 64'h2);
      cycle();
      check("basic_e3_valid", 64'(ov0), 64'h0);

      // Round-robin fairness over 12 preloaded beats.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         in_valid = 4'hF;
         for (int c = 0; c < NC; c++)
            in_data[c*DW +: DW] = 64'(k * 16 + c);
         cycle();
      end
      in_valid  = '0;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         check("rrseq_valid", 64'(ov0), 64'h1);
         check("rrseq_ch",    64'(oc0), 64'(i % 4));
         cycle();
      end

      // Two beats each on ch1 and ch3.
      do_reset();
      for (int k = 0; k < 2; k++) begin
         in_valid = 4'b1010;
         in_data[1*DW +: DW] = 64'(16'h1100 + k);
         in_data[3*DW +: DW] = 64'(16'h3300 + k);
         cycle();
      end
      in_valid  = '0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("prseq_valid", 64'(ov1 & ov0), 64'h1);
         check("prseq_ch",    64'(oc1), 64'(exp_pr[i]));
         check("rralt_ch",    64'(oc0), 64'(exp_rr[i]));
         cycle();
      end

      // Fill ch0 under backpressure.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         in_valid = 4'b0001;
         in_data[0 +: DW] = 64'h100 + 64'(k);
         cycle();
      end
      check("full_ready", 64'(rdy0[0]), 64'h0);
      check("full_valid", 64'(ov0),     64'h1);
      check("full_data",  od0,          64'h100);
      for (int k = 0; k < 10; k++) begin
         cycle();
         check("hold_data",  od0,          64'h100);
         check("hold_ready", 64'(rdy0[0]), 64'h0);
      end

      // Drain while pushing: push and pop coincide once not full.
      out_ready = 1'b1;
      check("pp_full_ready", 64'(rdy0[0]), 64'h0);
      for (int k = 0; k < 8; k++) begin
         in_data[0 +: DW] = 64'h200 + 64'(k);
         cycle();
         check("pp_ready", 64'(rdy0[0]), 64'h1);
         if (k == 0) check("pp_first", od0, 64'h101);
      end

      // Reset with beats buffered and out_valid high.
      out_ready = 1'b0;
      in_valid  = 4'b0110;
      in_data[1*DW +: DW] = 64'h777;
      in_data[2*DW +: DW] = 64'h888;
      cycle();
      in_valid = '0;
      cycle();
      check("mid_valid", 64'(ov0), 64'h1);
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cycle();
         check("no_stale", 64'(ov0 | ov1), 64'h0);
      end

      // Random traffic with varying downstream acceptance.
      for (int k = 0; k < 400; k++) begin
         if (k == 200) do_reset();
         in_valid = NC'($urandom);
         for (int c = 0; c < NC; c++)
            in_data[c*DW +: DW] = {$urandom, $urandom};
         out_ready = (($urandom % 4) <= 32'((k / 50) % 4));
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
